// File: rtl/stm_pkg.sv
// stm_pkg: shared types and constants for the STM segment swapchain
package stm_pkg;
  typedef enum logic [1:0] {
    MODE_IMMEDIATE = 2'd0,
    MODE_SYNC_IDX  = 2'd1,
    MODE_EXT_TRIG  = 2'd2,
    MODE_RESERVED  = 2'd3
  } transition_mode_t;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COUNT   = 2'd2,
    ST_STOPPED = 2'd3
  } swapchain_state_t;
  localparam logic [63:0] REP_INFINITE = '1;
endpackage

// File: rtl/stm_wrap_detect.sv
// stm_wrap_detect: registers one segment index and flags its return to zero
module stm_wrap_detect #(
  parameter int IDX_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IDX_WIDTH-1:0] idx_in,
  output logic [IDX_WIDTH-1:0] idx_out,
  output logic                 wrap
);
  always_ff @(posedge CLK) idx_out <= RST ? '0 : idx_in;
  always_comb wrap = idx_in == '0 && idx_out != '0;
endmodule

// File: rtl/stm_swapchain_multi.sv
// stm_swapchain_multi: selects the active STM segment and counts its loop repetitions
module stm_swapchain_multi
  import stm_pkg::*;
#(
  parameter int NUM_SEGMENTS = 2,
  parameter int IDX_WIDTH = 16,
  parameter int REP_WIDTH = 32,
  localparam int SEG_WIDTH = $clog2(NUM_SEGMENTS)
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   UPDATE_SETTINGS,
  input  logic [SEG_WIDTH-1:0]                   REQ_SEGMENT,
  input  logic [1:0]                             REQ_MODE,
  input  logic [NUM_SEGMENTS-1:0][REP_WIDTH-1:0] REP,
  input  logic                                   EXT_TRIG,
  input  logic [NUM_SEGMENTS-1:0][IDX_WIDTH-1:0] IDX_IN,
  output logic [SEG_WIDTH-1:0]                   SEGMENT,
  output logic                                   STOP,
  output logic                                   PENDING,
  output logic [NUM_SEGMENTS-1:0][IDX_WIDTH-1:0] IDX_OUT
);
  localparam logic [REP_WIDTH-1:0] INF = REP_INFINITE[REP_WIDTH-1:0];
  swapchain_state_t state, run_state, base;
  transition_mode_t req_mode;
  logic [SEG_WIDTH-1:0] req_seg, nxt_seg;
  logic [REP_WIDTH-1:0] req_rep, cur_rep, loop_cnt, nxt_rep;
  logic [NUM_SEGMENTS-1:0] wrap;
  logic upd, upd_imm, trig, take, cnt_wrap;
  for (genvar k = 0; k < NUM_SEGMENTS; k++) begin : g_seg
    stm_wrap_detect #(.IDX_WIDTH(IDX_WIDTH)) u_wrap (
      .CLK(CLK),
      .RST(RST),
      .idx_in(IDX_IN[k]),
      .idx_out(IDX_OUT[k]),
      .wrap(wrap[k])
    );
  end
  // run_state keeps the active segment's counting status alive while a request waits
  always_comb begin
    upd = UPDATE_SETTINGS && int'(REQ_SEGMENT) < NUM_SEGMENTS;
    upd_imm = REQ_MODE == MODE_IMMEDIATE || REQ_MODE == MODE_RESERVED;
    base = state == ST_WAIT ? run_state : state;
    trig = state == ST_WAIT && (req_mode == MODE_SYNC_IDX ? wrap[req_seg] : EXT_TRIG);
    take = upd ? upd_imm : trig;
    nxt_seg = upd ? REQ_SEGMENT : req_seg;
    nxt_rep = upd ? REP[REQ_SEGMENT] : req_rep;
    cnt_wrap = base == ST_COUNT && wrap[SEGMENT];
    PENDING = state == ST_WAIT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_RUN;
      run_state <= ST_RUN;
      SEGMENT <= '0;
      STOP <= 1'b0;
      req_seg <= '0;
      req_mode <= MODE_IMMEDIATE;
      req_rep <= INF;
      cur_rep <= INF;
      loop_cnt <= '0;
    end else if (take) begin
      SEGMENT <= nxt_seg;
      cur_rep <= nxt_rep;
      loop_cnt <= '0;
      STOP <= 1'b0;
      state <= nxt_rep == INF ? ST_RUN : ST_COUNT;
    end else if (upd) begin
      state <= ST_WAIT;
      run_state <= base;
      req_seg <= REQ_SEGMENT;
      req_mode <= transition_mode_t'(REQ_MODE);
      req_rep <= REP[REQ_SEGMENT];
    end else if (cnt_wrap) begin
      if (loop_cnt == cur_rep) begin
        STOP <= 1'b1;
        run_state <= ST_STOPPED;
        state <= state == ST_WAIT ? ST_WAIT : ST_STOPPED;
      end else begin
        loop_cnt <= loop_cnt + REP_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_stm_swapchain_multi.sv
// tb_stm_swapchain_multi: directed scoreboard bench for the segment swapchain
module tb_stm_swapchain_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, upd, ext, upd3;
  logic [1:0] req_seg, req_mode, req_seg3, seg, seg3, e_seg3;
  logic [3:0][31:0] rep;
  logic [3:0][15:0] idx, idx_o;
  logic [2:0][31:0] rep3;
  logic [2:0][15:0] idx3, idx3_o;
  logic stop, pend, stop3, pend3;
  typedef struct {
    logic [1:0]  seg;
    logic        stop;
    logic        pend;
    logic [63:0] idx;
    logic [1:0]  seg3;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;

  stm_swapchain_multi #(.NUM_SEGMENTS(4), .IDX_WIDTH(16), .REP_WIDTH(32)) u4 (
    .CLK(clk), .RST(rst), .UPDATE_SETTINGS(upd), .REQ_SEGMENT(req_seg), .REQ_MODE(req_mode),
    .REP(rep), .EXT_TRIG(ext), .IDX_IN(idx), .SEGMENT(seg), .STOP(stop), .PENDING(pend),
    .IDX_OUT(idx_o));
  stm_swapchain_multi #(.NUM_SEGMENTS(3), .IDX_WIDTH(16), .REP_WIDTH(32)) u3 (
    .CLK(clk), .RST(rst), .UPDATE_SETTINGS(upd3), .REQ_SEGMENT(req_seg3), .REQ_MODE(req_mode),
    .REP(rep3), .EXT_TRIG(ext), .IDX_IN(idx3), .SEGMENT(seg3), .STOP(stop3), .PENDING(pend3),
    .IDX_OUT(idx3_o));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("SEGMENT", 64'(seg), 64'(e.seg));
      chk("STOP", 64'(stop), 64'(e.stop));
      chk("PENDING", 64'(pend), 64'(e.pend));
      chk("IDX_OUT", idx_o, e.idx);
      chk("SEGMENT3", 64'(seg3), 64'(e.seg3));
      chk("STOP3", 64'(stop3), 64'd0);
      chk("PENDING3", 64'(pend3), 64'd0);
      chk("IDX_OUT3", 64'(idx3_o), 64'd0);
    end
  end

  task automatic step(input logic [1:0] es, input logic est, input logic ep);
    exp_t e;
    e.seg = es;
    e.stop = est;
    e.pend = ep;
    e.idx = rst ? 64'd0 : idx;
    e.seg3 = e_seg3;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; upd = 1'b0; upd3 = 1'b0; ext = 1'b0;
    req_seg = '0; req_seg3 = '0; req_mode = '0;
    rep = '1; rep3 = '1; idx = {4{16'd5}}; idx3 = '0; e_seg3 = 2'd0;
    step(0, 0, 0); step(0, 0, 0);
    rst = 1'b0; step(0, 0, 0);
    upd = 1'b1; req_seg = 2'd3; req_mode = 2'd0;
    upd3 = 1'b1; req_seg3 = 2'd2; e_seg3 = 2'd2;
    step(3, 0, 0);
    upd = 1'b0; upd3 = 1'b0; step(3, 0, 0);
    upd = 1'b1; req_seg = 2'd1; req_mode = 2'd1; rep[1] = 32'd1; idx[1] = 16'd2;
    step(3, 0, 1);
    upd = 1'b0; rep[1] = 32'd0; idx[1] = 16'd0; step(1, 0, 0);
    idx[1] = 16'd1; step(1, 0, 0);
    idx[1] = 16'd0; step(1, 0, 0);
    idx[1] = 16'd1; step(1, 0, 0);
    idx[1] = 16'd0; step(1, 1, 0);
    step(1, 1, 0);
    upd = 1'b1; req_seg = 2'd2; req_mode = 2'd2; rep[2] = '1; step(1, 1, 1);
    req_seg = 2'd0; rep[0] = 32'd0; step(1, 1, 1);
    upd = 1'b0; step(1, 1, 1);
    ext = 1'b1; step(0, 0, 0);
    ext = 1'b0; step(0, 0, 0);
    idx[0] = 16'd0; step(0, 1, 0);
    upd3 = 1'b1; req_seg3 = 2'd3; req_mode = 2'd2; step(0, 1, 0);
    req_mode = 2'd0; step(0, 1, 0);
    upd3 = 1'b0; step(0, 1, 0);
    upd = 1'b1; req_seg = 2'd2; req_mode = 2'd1; step(0, 1, 1);
    upd = 1'b0; rst = 1'b1; e_seg3 = 2'd0; step(0, 0, 0);
    rst = 1'b0; step(0, 0, 0);
    idx[2] = 16'd0; step(0, 0, 0);
    idx[0] = 16'd3; step(0, 0, 0);
    upd = 1'b1; req_seg = 2'd0; req_mode = 2'd0; rep[0] = 32'd0; idx[0] = 16'd0; step(0, 0, 0);
    upd = 1'b0; idx[0] = 16'd4; step(0, 0, 0);
    idx[0] = 16'd0; step(0, 1, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
